// File: rtl/bram_copy_engine_if.sv
// ----------------------------------------------------------------------------
// bram_copy_engine_if
// Memory-side bus between the copy engine and a dual-port block RAM.
// Port 0 is used read-only, port 1 write-only.
//   clk_en, singleportmode        : static RAM configuration
//   port_en_0, wr_en_0            : port 0 enable / write enable
//   addr_in_0, data_in_0          : port 0 address / write data
//   data_out_0                    : port 0 read data (from the RAM)
//   port_en_1, wr_en_1            : port 1 enable / write enable
//   addr_in_1, data_in_1          : port 1 address / write data
// Modports: master = copy engine, slave = RAM.
// ----------------------------------------------------------------------------
interface bram_copy_engine_if #(
  parameter int DWIDTH = 8,
  parameter int ADDR_W = 8
);
  logic              clk_en;
  logic              singleportmode;
  logic              port_en_0;
  logic              wr_en_0;
  logic [ADDR_W-1:0] addr_in_0;
  logic [DWIDTH-1:0] data_in_0;
  logic [DWIDTH-1:0] data_out_0;
  logic              port_en_1;
  logic              wr_en_1;
  logic [ADDR_W-1:0] addr_in_1;
  logic [DWIDTH-1:0] data_in_1;

  modport master (
    output clk_en, singleportmode,
    output port_en_0, wr_en_0, addr_in_0, data_in_0,
    output port_en_1, wr_en_1, addr_in_1, data_in_1,
    input  data_out_0
  );

  modport slave (
    input  clk_en, singleportmode,
    input  port_en_0, wr_en_0, addr_in_0, data_in_0,
    input  port_en_1, wr_en_1, addr_in_1, data_in_1,
    output data_out_0
  );
endinterface

// File: rtl/bram_copy_engine.sv
// ----------------------------------------------------------------------------
// bram_copy_engine
// Copies a block of words inside one dual-port RAM: reads through port 0,
// writes through port 1, one word per cycle. Overlapping copies are made
// safe by choosing the walk direction (memmove semantics).
//   clk, rst        : clock, synchronous active-high reset
//   start           : copy request, sampled only when idle
//   src_addr        : first source word
//   dst_addr        : first destination word
//   length          : word count, 0..DEPTH
//   busy            : copy in progress (RUN / DRAIN)
//   done, err       : one-cycle completion / rejection pulses
//   words_done      : words written in the current or last copy
//   mem             : RAM bus (bram_copy_engine_if.master)
// ----------------------------------------------------------------------------
module bram_copy_engine #(
  parameter int DWIDTH    = 8,
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = 8,
  parameter int READ_SYNC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    src_addr,
  input  logic [ADDR_W-1:0]    dst_addr,
  input  logic [ADDR_W:0]      length,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_W:0]      words_done,
  bram_copy_engine_if.master   mem
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [ADDR_W+1:0] DEPTH_L = (ADDR_W+2)'(DEPTH);

  logic [1:0]        state;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_dst;
  logic [ADDR_W:0]   rem;
  logic              desc;
  logic              vld_p1;
  logic [ADDR_W-1:0] wr_addr_p1;

  logic [ADDR_W+1:0] src_end;
  logic [ADDR_W+1:0] dst_end;
  logic              reject;
  logic              trivial;
  logic              desc_n;
  logic              wr_fire;

  // Range checks carry two extra bits so addr+length cannot wrap.
  assign src_end = {2'b00, src_addr} + {1'b0, length};
  assign dst_end = {2'b00, dst_addr} + {1'b0, length};
  assign reject  = (src_end > DEPTH_L) || (dst_end > DEPTH_L);
  assign trivial = (length == '0) || (src_addr == dst_addr);
  // Destination starting inside the source range would overwrite unread
  // source words on an ascending walk, so walk from the top instead.
  assign desc_n  = (src_addr < dst_addr) && ({2'b00, dst_addr} < src_end);

  assign busy    = (state == S_RUN) || (state == S_DRAIN);
  assign wr_fire = (READ_SYNC != 0) ? vld_p1 : (state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      done       <= 1'b0;
      err        <= 1'b0;
      words_done <= '0;
      vld_p1     <= 1'b0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      vld_p1 <= (READ_SYNC != 0) && (state == S_RUN);
      if (wr_fire) words_done <= words_done + 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            words_done <= '0;
            if (reject) begin
              err <= 1'b1;
            end else if (trivial) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              desc  <= desc_n;
              rem   <= length;
              rd_addr <= desc_n ? src_addr + length[ADDR_W-1:0] - 1'b1 : src_addr;
              wr_dst  <= desc_n ? dst_addr + length[ADDR_W-1:0] - 1'b1 : dst_addr;
            end
          end
        end
        S_RUN: begin
          rd_addr <= desc ? rd_addr - 1'b1 : rd_addr + 1'b1;
          wr_dst  <= desc ? wr_dst - 1'b1 : wr_dst + 1'b1;
          rem     <= rem - 1'b1;
          if (rem == 1) begin
            if (READ_SYNC != 0) begin
              state <= S_DRAIN;
            end else begin
              state <= S_FIN;
              done  <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          state <= S_FIN;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p1: destination of the word read last cycle (registered RAM read)
  always_ff @(posedge clk) begin
    wr_addr_p1 <= wr_dst;
  end

  always_comb begin
    mem.clk_en         = 1'b1;
    mem.singleportmode = 1'b0;
    mem.wr_en_0        = 1'b0;
    mem.data_in_0      = {DWIDTH{1'b0}};
    mem.port_en_0      = (state == S_RUN);
    mem.addr_in_0      = (state == S_RUN) ? rd_addr : '0;
    mem.port_en_1      = wr_fire;
    mem.wr_en_1        = wr_fire;
    mem.addr_in_1      = '0;
    mem.data_in_1      = '0;
    if (wr_fire) begin
      mem.addr_in_1 = (READ_SYNC != 0) ? wr_addr_p1 : wr_dst;
      mem.data_in_1 = mem.data_out_0;
    end
  end

endmodule

// File: tb/tb_bram_copy_engine.sv
// ----------------------------------------------------------------------------
// tb_bram_copy_engine
// Two engines (READ_SYNC=0 and READ_SYNC=1) share one stimulus stream, each
// with its own RAM and its own memmove-level reference model.
// ----------------------------------------------------------------------------
module tb_bram_copy_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [8:0] length;
  logic       pl_en;
  logic [7:0] pl_addr;
  logic [7:0] pl_data;

  logic       busy_w [2];
  logic       done_w [2];
  logic       err_w  [2];
  logic [8:0] wd_w   [2];

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s [read_sync=%0d] @%0t: got %0d, expected %0d", nm, inst, $time, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int RS = g;

    bram_copy_engine_if #(.DWIDTH(8), .ADDR_W(8)) bus ();

    bram_copy_engine #(.DWIDTH(8), .DEPTH(256), .ADDR_W(8), .READ_SYNC(RS)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .length     (length),
      .busy       (busy_w[g]),
      .done       (done_w[g]),
      .err        (err_w[g]),
      .words_done (wd_w[g]),
      .mem        (bus.master)
    );

    // RAM with a bench-side preload port
    logic [7:0] mem [256];
    logic [7:0] rd_q = 8'h00;
    always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (bus.port_en_1 && bus.wr_en_1) mem[bus.addr_in_1] <= bus.data_in_1;
      if (bus.port_en_0) rd_q <= mem[bus.addr_in_0];
    end
    assign bus.data_out_0 = (RS != 0) ? rd_q : mem[bus.addr_in_0];

    // Reference: request timing from the word count, data from memmove
    logic [7:0] refm [256];
    logic [7:0] snap [256];
    int m_cyc = -1;
    int m_fin = 0;
    int m_len = 0;
    int m_src = 0;
    int m_dst = 0;
    int m_wd  = 0;
    bit m_copy = 0;
    bit m_desc = 0;
    bit m_err  = 0;

    always @(posedge clk) begin
      m_err = 0;
      if (pl_en) refm[pl_addr] = pl_data;
      if (rst) begin
        m_cyc = -1;
        m_wd  = 0;
      end else begin
        if (m_cyc >= 0) begin
          if (m_cyc == m_fin) m_cyc = -1;
          else m_cyc++;
        end else if (start) begin
          m_wd = 0;
          if (int'(src_addr) + int'(length) > 256 || int'(dst_addr) + int'(length) > 256) begin
            m_err = 1;
          end else begin
            m_src  = int'(src_addr);
            m_dst  = int'(dst_addr);
            m_len  = int'(length);
            m_copy = (m_len != 0) && (m_src != m_dst);
            m_desc = (m_src < m_dst) && (m_dst < m_src + m_len);
            m_fin  = m_copy ? m_len + 1 + RS : 1;
            snap   = refm;
            m_cyc  = 1;
          end
        end
        if (m_cyc >= 1 && m_copy) begin
          m_wd = m_cyc - 1 - RS;
          if (m_wd < 0) m_wd = 0;
          if (m_wd > m_len) m_wd = m_len;
        end
      end
    end

    always @(negedge clk) begin
      bit act, rd_exp, wr_exp;
      int ri, wi, rd_a, wr_a, wr_s, nbad;
      act    = (m_cyc >= 1) && m_copy;
      ri     = m_cyc - 1;
      wi     = m_cyc - 1 - RS;
      rd_exp = act && ri >= 0 && ri < m_len;
      wr_exp = act && wi >= 0 && wi < m_len;
      rd_a   = m_desc ? m_src + m_len - 1 - ri : m_src + ri;
      wr_a   = m_desc ? m_dst + m_len - 1 - wi : m_dst + wi;
      wr_s   = m_desc ? m_src + m_len - 1 - wi : m_src + wi;
      chk("busy", RS, int'(busy_w[g]), int'(act && m_cyc < m_fin));
      chk("done", RS, int'(done_w[g]), int'(m_cyc >= 1 && m_cyc == m_fin));
      chk("err", RS, int'(err_w[g]), int'(m_err));
      chk("words_done", RS, int'(wd_w[g]), m_wd);
      chk("static_pins", RS,
          int'({bus.clk_en, bus.singleportmode, bus.wr_en_0, |bus.data_in_0}), 8);
      chk("port_en_0", RS, int'(bus.port_en_0), int'(rd_exp));
      chk("addr_in_0", RS, int'(bus.addr_in_0), rd_exp ? rd_a : 0);
      chk("port_en_1", RS, int'(bus.port_en_1), int'(wr_exp));
      chk("wr_en_1", RS, int'(bus.wr_en_1), int'(wr_exp));
      chk("addr_in_1", RS, int'(bus.addr_in_1), wr_exp ? wr_a : 0);
      chk("data_in_1", RS, int'(bus.data_in_1), wr_exp ? int'(snap[wr_s]) : 0);
      chk("collision_flag", RS,
          int'(bus.port_en_0 && bus.port_en_1 && bus.addr_in_0 == bus.addr_in_1), 0);
      if (wr_exp) refm[wr_a] = snap[wr_s];
      if (m_copy && m_cyc >= 1 && m_cyc == m_fin) begin
        nbad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] != refm[a]) nbad++;
        chk("mem_image_bad_words", RS, nbad, 0);
      end
    end
  end

  task automatic preload(input int a, input int v);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = 8'(a); pl_data = 8'(v);
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request and record the cycle (after the sampling edge) at
  // which each engine first shows done / err; -1 when never seen.
  task automatic do_copy(input int s, input int d, input int l, input bit poke,
                         output int ld0, output int ld1, output int le0, output int le1);
    @(negedge clk);
    start = 1'b1; src_addr = 8'(s); dst_addr = 8'(d); length = 9'(l);
    ld0 = -1; ld1 = -1; le0 = -1; le1 = -1;
    for (int c = 1; c <= l + 12; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (poke && c == 2) begin
        start = 1'b1; src_addr = 8'($urandom); dst_addr = 8'($urandom);
        length = 9'($urandom_range(0, 256));
      end
      if (poke && c == 3) start = 1'b0;
      if (done_w[0] && ld0 < 0) ld0 = c;
      if (done_w[1] && ld1 < 0) ld1 = c;
      if (err_w[0]  && le0 < 0) le0 = c;
      if (err_w[1]  && le1 < 0) le1 = c;
    end
  endtask

  task automatic copy_expect(input int s, input int d, input int l, input bit poke);
    int ld0, ld1, le0, le1;
    bit bad;
    int e0, e1;
    bad = (s + l > 256) || (d + l > 256);
    do_copy(s, d, l, poke && !bad && l >= 3 && s != d, ld0, ld1, le0, le1);
    if (bad) begin
      e0 = -1; e1 = -1;
    end else if (l == 0 || s == d) begin
      e0 = 1; e1 = 1;
    end else begin
      e0 = l + 1; e1 = l + 2;
    end
    chk("done_latency", 0, ld0, e0);
    chk("done_latency", 1, ld1, e1);
    chk("err_latency", 0, le0, bad ? 1 : -1);
    chk("err_latency", 1, le1, bad ? 1 : -1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 0, int'(busy_w[0]), 0);
    chk("reset_words_done", 1, int'(wd_w[1]), 0);

    for (int a = 0; a < 256; a++) preload(a, int'($urandom_range(0, 255)));

    // Basic copy, both read latencies
    for (int i = 0; i < 4; i++) preload(16 + i, 160 + i);
    copy_expect(16, 64, 4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("basic_mem", 0, int'(g_inst[0].mem[64 + i]), 160 + i);
      chk("basic_mem", 1, int'(g_inst[1].mem[64 + i]), 160 + i);
    end
    chk("basic_words_done", 0, int'(wd_w[0]), 4);
    chk("basic_words_done", 1, int'(wd_w[1]), 4);

    // Overlapping copy forward by two words
    for (int i = 0; i < 8; i++) preload(32 + i, i);
    copy_expect(32, 34, 6, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("overlap_mem", 0, int'(g_inst[0].mem[34 + i]), i);
      chk("overlap_mem", 1, int'(g_inst[1].mem[34 + i]), i);
    end
    chk("overlap_head", 1, int'(g_inst[1].mem[33]), 1);

    // Rejections, empty and self copies, exact top-of-memory fit
    copy_expect(240, 0, 32, 1'b0);
    copy_expect(0, 241, 16, 1'b0);
    copy_expect(48, 80, 0, 1'b0);
    copy_expect(51, 51, 5, 1'b0);
    copy_expect(248, 0, 8, 1'b0);
    copy_expect(0, 128, 128, 1'b0);

    // Reset during the third RUN cycle
    @(negedge clk);
    start = 1'b1; src_addr = 8'h50; dst_addr = 8'h60; length = 9'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_busy", 0, int'(busy_w[0]), 0);
    chk("midreset_busy", 1, int'(busy_w[1]), 0);
    chk("midreset_words_done", 1, int'(wd_w[1]), 0);
    chk("midreset_port_en_1", 1, int'(g_inst[1].bus.port_en_1), 0);
    copy_expect(80, 96, 8, 1'b0);

    // Random requests, some with a start pulse while busy
    for (int n = 0; n < 30; n++) begin
      int s, d, l;
      s = int'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) d = s + int'($urandom_range(0, 6)) - 3;
      else d = int'($urandom_range(0, 255));
      if (d < 0) d = 0;
      if (d > 255) d = 255;
      l = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 256)) : int'($urandom_range(0, 24));
      copy_expect(s, d, l, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
